apb_wait_completer: RTL and testbench
=====================================

// Module: apb_wait_completer
//
// PURPOSE
//   APB4 completer with a byte-strobed register bank, a fixed number of wait
//   states per access, and error responses. Sits on the completer side of the
//   APB interface, opposite the bridge. It stresses the bridge's PREADY wait
//   handling and PSLVERR handling, which a zero-wait completer never exercises.
//
// PARAMETERS
//   ADDR_WIDTH   8             PADDR width; word index = paddr[ADDR_WIDTH-1:2]
//   DATA_WIDTH   32            PWDATA/PRDATA width
//   STRB_WIDTH   DATA_WIDTH/8  PSTRB width, one bit per byte lane
//   NUM_REGS     16            register count; legal byte addrs 0 .. 4*NUM_REGS-4
//   WAIT_CYCLES  2             PREADY-low cycles in each access phase (0..15)
//   ID_VALUE     32'hA9B0_0001 constant read value of register 0
//
// PORTS
//   pclk     in   1           clock, rising edge
//   presetn  in   1           reset, asynchronous, active-low
//   psel     in   1           completer select
//   penable  in   1           access phase
//   pwrite   in   1           1 = write, 0 = read
//   paddr    in   ADDR_WIDTH  byte address
//   pwdata   in   DATA_WIDTH  write data
//   pstrb    in   STRB_WIDTH  write byte enables
//   prdata   out  DATA_WIDTH  read data; valid only when pready & !pwrite, else 0
//   pready   out  1           transfer completes this cycle
//   pslverr  out  1           error response; valid only with pready, else 0
//
// BEHAVIOUR
//   Reset (presetn=0, async)
//   - State goes to IDLE and the wait counter clears.
//   - Registers 1..NUM_REGS-1 clear to 0.
//   - prdata=0, pready=0, pslverr=0 immediately.
//   - A transfer in progress is dropped; it produces no write and no response.
//   FSM states: IDLE, WAIT
//   - IDLE: on psel & !penable (setup), go to WAIT and load cnt = WAIT_CYCLES.
//   - WAIT, psel & penable & cnt != 0: pready = 0, cnt decrements.
//   - WAIT, psel & penable & cnt == 0: pready = 1 (combinational from state/cnt).
//     The write commits or the read data is driven. Next state is IDLE.
//   - WAIT, psel drops: abort to IDLE with no write and no counter update.
//   - IDLE, psel & penable with no setup seen: protocol violation, ignored.
//     pready stays 0.
//   - Back-to-back: a setup in the cycle after a completion is accepted normally.
//   Latency: the access phase lasts WAIT_CYCLES+1 cycles. WAIT_CYCLES=0 gives
//   a zero-wait completer.
//   Address decode (err = pslverr at completion)
//   - paddr[1:0] != 0: err. No write; prdata = 0.
//   - index >= NUM_REGS: err. No write; prdata = 0.
//   - Write to register 0 (ID): err. No change.
//   - Read of register 0 returns ID_VALUE.
//   - Register 1 (STATUS): [7:0] err_cnt, [15:8] xfer_cnt, upper bits 0.
//     Any write to it clears both counters and gives no err.
//   - Registers 2..NUM_REGS-1: read/write. Only byte lanes with pstrb=1 update.
//     pstrb = 0 is a legal no-op write.
//   Counters (update at the completing edge)
//   - xfer_cnt: +1 on every completed transfer, wraps 255 -> 0.
//   - err_cnt: +1 on every errored completion, saturates at 255.
//   - A STATUS write clears both counters; that write itself does not count.
//   - Aborted transfers count in neither counter.
//   pstrb is ignored on reads.
//
// TESTING
//   1. Reset, then read 0x00 -> pready low 2 cycles, then
//      prdata=32'hA9B0_0001, pslverr=0.
//   2. Write 0x08=32'h1122_3344 with pstrb=4'b0101, after 0x08 was
//      32'hFFFF_FFFF -> readback 32'hFF22_FF44.
//   3. Write 0x00, read 0x40 (NUM_REGS=16), and read 0x05 -> each gives
//      pslverr=1 with pready. Then STATUS reads err_cnt=3, xfer_cnt=3;
//      the STATUS read itself counts.
//   4. Drop psel after the 1st wait cycle of a write to 0x0C -> no pready;
//      0x0C is unchanged; xfer_cnt is unchanged.
//   5. Assert presetn low mid-WAIT of a write to 0x10 -> pready=0 at once;
//      afterwards 0x10 = 0 and the FSM is in IDLE.
//   6. WAIT_CYCLES=0 build: back-to-back writes -> pready=1 in each access
//      cycle with no idle gap between transfers.

Source files
------------

// File: rtl/apb_wait_completer.sv
// APB4 completer with a byte-strobed register bank, a fixed number of wait
// states in every access phase, and PSLVERR on bad addresses or ID writes.
// Register 0 is a read-only ID, register 1 holds transfer/error counters,
// registers 2..NUM_REGS-1 are plain read/write storage.
module apb_wait_completer #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_WIDTH-1:0] pstrb,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;
    logic [3:0]              cnt_next;

    logic [IDX_W-1:0]        index;
    logic [SEL_W-1:0]        sel;
    logic                    addr_err;
    logic                    err;
    logic                    status_clr;
    logic [7:0]              err_cnt;
    logic [7:0]              xfer_cnt;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   rd_word;

    // Word index decode; an unaligned or out-of-range address is an error,
    // and so is any write aimed at the read-only ID register.
    assign index      = paddr[ADDR_WIDTH-1:2];
    assign sel        = index[SEL_W-1:0];
    assign addr_err   = (paddr[1:0] != 2'b00) || (32'(index) >= NUM_REGS);
    assign err        = addr_err || (pwrite && (index == '0));
    assign status_clr = pwrite && !addr_err && (index == IDX_W'(1));

    // State register: FSM state and remaining wait count
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: setup loads the wait count, access phase counts it down
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                // psel & penable without a setup is a protocol violation and is ignored
                if (psel && !penable) begin
                    state_next = ST_WAIT;
                    cnt_next   = 4'(WAIT_CYCLES);
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    // requester abandoned the transfer; leave the counter alone
                    state_next = ST_IDLE;
                end else if (penable) begin
                    if (cnt != 4'd0) begin
                        cnt_next = cnt - 4'd1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    // a fresh setup while still selected restarts the wait
                    cnt_next = 4'(WAIT_CYCLES);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Read mux: ID constant, counter status word, or storage register
    always_comb begin
        rd_word = '0;
        if (index == '0) begin
            rd_word = ID_VALUE;
        end else if (index == IDX_W'(1)) begin
            rd_word[15:0] = {xfer_cnt, err_cnt};
        end else begin
            rd_word = regs[sel];
        end
    end

    // Outputs: pready straight from state/count, response qualified by pready
    always_comb begin
        pready  = (state == ST_WAIT) && psel && penable && (cnt == 4'd0);
        pslverr = pready && err;
        prdata  = '0;
        if (pready && !pwrite && !addr_err) begin
            prdata = rd_word;
        end
    end

    // Register bank: byte-lane writes to storage registers at completion
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (pready && pwrite && !err && (32'(index) >= 2)) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (pstrb[b]) begin
                    regs[sel][8*b +: 8] <= pwdata[8*b +: 8];
                end
            end
        end
    end

    // Status counters: wrapping transfer count, saturating error count
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            err_cnt  <= '0;
            xfer_cnt <= '0;
        end else if (pready) begin
            if (status_clr) begin
                err_cnt  <= '0;
                xfer_cnt <= '0;
            end else begin
                xfer_cnt <= xfer_cnt + 8'd1;
                if (err && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_wait_completer.sv
// Bench for apb_wait_completer: one instance with two wait states and one
// zero-wait instance. A driver issues APB transfers and queues the expected
// response; per-instance monitors pop and compare whenever pready is seen.
module tb_apb_wait_completer;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk;
    logic        presetn;
    logic        psel2;
    logic        psel0;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata2;
    logic        pready2;
    logic        pslverr2;
    logic [31:0] prdata0;
    logic        pready0;
    logic        pslverr0;

    exp_t q2[$];
    exp_t q0[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    apb_wait_completer #(.WAIT_CYCLES(2)) dut2 (
        .pclk(clk), .presetn(presetn), .psel(psel2), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
    );

    apb_wait_completer #(.WAIT_CYCLES(0)) dut0 (
        .pclk(clk), .presetn(presetn), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic mon_check(input bit w0, input logic [31:0] rd, input logic err);
        exp_t e;
        bit   empty;
        checks++;
        empty = w0 ? (q0.size() == 0) : (q2.size() == 0);
        if (empty) begin
            failures++;
            $display("FAIL unexpected_pready dut%0d rd=%h err=%b", w0 ? 0 : 2, rd, err);
        end else begin
            if (w0) e = q0.pop_front();
            else    e = q2.pop_front();
            if (rd !== e.rd || err !== e.err) begin
                failures++;
                $display("FAIL resp dut%0d got rd=%h err=%b want rd=%h err=%b",
                         w0 ? 0 : 2, rd, err, e.rd, e.err);
            end
        end
    endtask

    // Monitors: compare every completed response against the queue head
    always @(negedge clk) if (pready2 === 1'b1) mon_check(1'b0, prdata2, pslverr2);
    always @(negedge clk) if (pready0 === 1'b1) mon_check(1'b1, prdata0, pslverr0);

    // One APB transfer; starts and ends just after a rising edge
    task automatic xfer(input bit w0, input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd, input bit exp_err);
        exp_t e;
        int   waits;
        bit   got;
        e.rd  = wr ? 32'h0 : exp_rd;
        e.err = exp_err;
        if (w0) q0.push_back(e);
        else    q2.push_back(e);
        if (w0) psel0 = 1'b1;
        else    psel2 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        got   = 1'b0;
        while (!got && waits <= 20) begin
            @(negedge clk);
            if ((w0 ? pready0 : pready2) === 1'b1) got = 1'b1;
            else waits++;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL timeout dut%0d addr=%h no pready after %0d cycles", w0 ? 0 : 2, a, waits);
            if (w0) void'(q0.pop_back());
            else    void'(q2.pop_back());
        end else if (waits != (w0 ? 0 : 2)) begin
            failures++;
            $display("FAIL latency dut%0d addr=%h waits=%0d want=%0d", w0 ? 0 : 2, a, waits, w0 ? 0 : 2);
        end
        @(posedge clk); #1;
        psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input bit w0, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input bit err);
        xfer(w0, 1'b1, a, d, s, 32'h0, err);
    endtask

    task automatic rd(input bit w0, input logic [7:0] a, input logic [31:0] exp_rd, input bit err);
        xfer(w0, 1'b0, a, 32'h0, 4'hF, exp_rd, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        presetn = 1'b0; psel2 = 1'b0; psel0 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        #3;
        chk("reset_pready", {31'b0, pready2}, 32'h0);
        chk("reset_pslverr", {31'b0, pslverr2}, 32'h0);
        chk("reset_prdata", prdata2, 32'h0);
        #20;
        @(posedge clk); #1 presetn = 1'b1;
        @(posedge clk); #1;

        // ID read with two wait states
        rd(0, 8'h00, 32'hA9B0_0001, 0);

        // byte-strobed write merge, then a no-op zero-strobe write
        wr(0, 8'h08, 32'hFFFF_FFFF, 4'hF, 0);
        wr(0, 8'h08, 32'h1122_3344, 4'b0101, 0);
        rd(0, 8'h08, 32'hFF22_FF44, 0);
        wr(0, 8'h08, 32'h0000_0000, 4'b0000, 0);
        rd(0, 8'h08, 32'hFF22_FF44, 0);
        wr(0, 8'h3C, 32'h0BAD_CAFE, 4'hF, 0);
        rd(0, 8'h3C, 32'h0BAD_CAFE, 0);

        // error responses and counters
        wr(0, 8'h04, 32'hDEAD_BEEF, 4'hF, 0);
        wr(0, 8'h00, 32'h1234_5678, 4'hF, 1);
        rd(0, 8'h40, 32'h0, 1);
        rd(0, 8'h05, 32'h0, 1);
        rd(0, 8'h00, 32'hA9B0_0001, 0);
        rd(0, 8'h04, 32'h0000_0403, 0);
        rd(0, 8'h04, 32'h0000_0503, 0);

        // abort: psel drops after the first wait cycle of a write
        wr(0, 8'h0C, 32'h1234_5678, 4'hF, 0);
        wr(0, 8'h04, 32'h0, 4'hF, 0);
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk); chk("abort_wait_pready", {31'b0, pready2}, 32'h0);
        @(posedge clk); #1 psel2 = 1'b0; penable = 1'b0;
        @(negedge clk); chk("abort_drop_pready", {31'b0, pready2}, 32'h0);
        @(posedge clk); #1;
        rd(0, 8'h04, 32'h0000_0000, 0);
        rd(0, 8'h0C, 32'h1234_5678, 0);

        // access phase without setup is ignored
        psel2 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h00;
        repeat (3) begin
            @(negedge clk); chk("nosetup_pready", {31'b0, pready2}, 32'h0);
        end
        @(posedge clk); #1 psel2 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rd(0, 8'h04, 32'h0000_0200, 0);

        // reset in the completing cycle of a write
        wr(0, 8'h10, 32'hCAFE_F00D, 4'hF, 0);
        psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 presetn = 1'b0;
        #1;
        chk("rst_mid_pready", {31'b0, pready2}, 32'h0);
        chk("rst_mid_pslverr", {31'b0, pslverr2}, 32'h0);
        chk("rst_mid_prdata", prdata2, 32'h0);
        psel2 = 1'b0; penable = 1'b0;
        @(posedge clk); #1 presetn = 1'b1;
        @(posedge clk); #1;
        rd(0, 8'h10, 32'h0, 0);
        rd(0, 8'h00, 32'hA9B0_0001, 0);
        rd(0, 8'h04, 32'h0000_0200, 0);

        // zero-wait instance: back-to-back transfers with no idle gap
        c0 = cyc;
        wr(1, 8'h08, 32'hA5A5_0001, 4'hF, 0);
        wr(1, 8'h0C, 32'hA5A5_0002, 4'hF, 0);
        wr(1, 8'h10, 32'hA5A5_0003, 4'hF, 0);
        chk("b2b_cycles", 32'(cyc - c0), 32'd6);
        rd(1, 8'h08, 32'hA5A5_0001, 0);
        rd(1, 8'h0C, 32'hA5A5_0002, 0);
        rd(1, 8'h10, 32'hA5A5_0003, 0);

        // error counter saturates, transfer counter wraps
        wr(1, 8'h04, 32'h0, 4'hF, 0);
        for (int i = 0; i < 257; i++) begin
            rd(1, (i % 2 == 1) ? 8'h41 : 8'h80, 32'h0, 1);
        end
        rd(1, 8'h04, 32'h0000_01FF, 0);

        repeat (3) @(posedge clk);
        chk("queues_drained", 32'(q2.size() + q0.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
